// File: rtl/wb_arbiter.sv
// Write-back merge stage: one holding slot per execution source, arbitrated onto the
// single register-file write port with fixed priority plus a starvation guard.
module wb_arbiter #(
  parameter int unsigned NSRC         = 3,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSRC-1:0]        src_valid_i,
  output logic [NSRC-1:0]        src_ready_o,
  input  logic [NSRC*ADDR_W-1:0] src_waddr_i,
  input  logic [NSRC*DATA_W-1:0] src_wdata_i,
  output logic                   we_o,
  output logic [ADDR_W-1:0]      waddr_o,
  output logic [DATA_W-1:0]      wdata_o,
  output logic [2**ADDR_W-1:0]   pend_rd_o
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic [NSRC-1:0]   slot_valid_q;
  logic [ADDR_W-1:0] slot_addr_q [NSRC];
  logic [DATA_W-1:0] slot_data_q [NSRC];
  logic [CntW-1:0]   cnt_q       [NSRC];

  logic [NSRC-1:0] starved;
  logic [NSRC-1:0] cand;
  logic [NSRC-1:0] grant;
  logic [NSRC-1:0] accept;
  logic [NSRC-1:0] addr_nz;

  always_comb begin
    starved = '0;
    addr_nz = '0;
    for (int i = 0; i < NSRC; i++) begin
      starved[i] = slot_valid_q[i] && (cnt_q[i] == CntMax);
      addr_nz[i] = |src_waddr_i[i*ADDR_W +: ADDR_W];
    end
  end

  // Starved slots take precedence; lowest index wins within the chosen set.
  assign cand        = (|starved) ? starved : slot_valid_q;
  assign grant       = cand & (~cand + NSRC'(1));
  assign src_ready_o = {NSRC{rst_n}} & (~slot_valid_q | grant);
  assign accept      = src_valid_i & src_ready_o;

  always_comb begin
    we_o    = |grant;
    waddr_o = '0;
    wdata_o = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant[i]) begin
        waddr_o = slot_addr_q[i];
        wdata_o = slot_data_q[i];
      end
    end
  end

  always_comb begin
    pend_rd_o = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (slot_valid_q[i]) begin
        pend_rd_o[slot_addr_q[i]] = 1'b1;
      end
    end
    pend_rd_o[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid_q <= '0;
      for (int i = 0; i < NSRC; i++) begin
        slot_addr_q[i] <= '0;
        slot_data_q[i] <= '0;
        cnt_q[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (accept[i]) begin
          // A write to x0 completes the handshake but is never held.
          slot_valid_q[i] <= addr_nz[i];
          slot_addr_q[i]  <= src_waddr_i[i*ADDR_W +: ADDR_W];
          slot_data_q[i]  <= src_wdata_i[i*DATA_W +: DATA_W];
          cnt_q[i]        <= '0;
        end else if (grant[i]) begin
          slot_valid_q[i] <= 1'b0;
          cnt_q[i]        <= '0;
        end else if (slot_valid_q[i] && (cnt_q[i] != CntMax)) begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back merge stage directly upstream of the general register file.
- Collects results from NSRC execution sources (index 0 = LSU, 1 = MUL/DIV, 2 = ALU) through valid/ready handshakes, one holding slot per source.
- Arbitrates the slots onto the single register-file write port (we/waddr/wdata), with fixed priority plus a starvation guard.
- Exports a pending-destination bitmask that the decode-stage hazard logic consumes.

Parameters:
- NSRC, 3: number of write-back sources. Legal range 2..8.
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.
- STARVE_LIMIT, 4: cycles a valid slot may lose arbitration before it is force-granted. Must be ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- src_valid_i  in  NSRC  source i presents a result
- src_ready_o  out  NSRC  slot i can accept this cycle
- src_waddr_i  in  NSRC*ADDR_W  destination of source i; packed, source i at bits [i*ADDR_W +: ADDR_W]
- src_wdata_i  in  NSRC*DATA_W  result of source i; packed the same way
- we_o  out  1  register-file write enable
- waddr_o  out  ADDR_W  register-file write address
- wdata_o  out  DATA_W  register-file write data
- pend_rd_o  out  2**ADDR_W  bit r set while any slot holds a write to register r; bit 0 is always 0

Behaviour:
- Reset (rst_n==0 at posedge): all slots empty and all wait counters 0.
  - While rst_n==0, src_ready_o is forced to all-0.
  - Consequence: we_o=0, waddr_o=0, wdata_o=0, pend_rd_o=0.
- Slot i state: valid, addr, data, and wait counter cnt_i. cnt_i is $clog2(STARVE_LIMIT+1) bits wide.
- Ready rule: src_ready_o[i] = rst_n & (~slot_valid[i] | grant[i]). This is combinational and does not depend on src_valid_i.
- Accept: src_valid_i[i] & src_ready_o[i] at posedge.
  - addr != 0: slot loads addr/data, valid=1, cnt_i=0.
  - addr == 0: the handshake completes, the result is discarded, and the slot stays or becomes empty.
- Grant and eligibility:
  - Only slots valid at the start of the cycle are eligible.
  - There is no same-cycle bypass, so latency from accept to write is ≥1 cycle.
- Grant selection, combinational, exactly one grant when any slot is valid:
  - If any valid slot has cnt_i == STARVE_LIMIT, grant the lowest-index such slot.
  - Otherwise grant the lowest-index valid slot.
- Write port, combinational from the granted slot:
  - we_o=1, waddr_o=slot addr, wdata_o=slot data. The register file writes at the end of that cycle.
  - With no grant: we_o=0, waddr_o=0, wdata_o=0.
- Granted slot at posedge: it empties unless it accepts a new result in the same cycle, in which case it reloads and cnt resets to 0. This gives full throughput of 1 result per source per cycle when that source is the sole requester.
- Non-granted valid slot: cnt_i increments each cycle and saturates at STARVE_LIMIT.
- pend_rd_o is the OR over valid slots of the one-hot decode of addr. It is combinational from slot state, not from the inputs.
- Ordering guarantee: the issue logic guarantees no two sources are in flight to the same rd at once. No same-address ordering logic exists in this block.
- Reset asserted mid-operation discards all held results; the next cycle shows we_o=0.
- The maximum wait of any slot is bounded by STARVE_LIMIT+NSRC-1 cycles after it becomes valid.

Test Plan:
1. Single write: cycle 0 src_valid=3'b100, addr=5, data=0xDEADBEEF.
   - Cycle 1: we_o=1, waddr_o=5, wdata_o=0xDEADBEEF, pend_rd_o=1<<5.
   - Cycle 2: we_o=0, pend_rd_o=0.
2. Priority: cycle 0 all three sources valid, addr 1/2/3.
   - Cycle 1 writes rd1, cycle 2 writes rd2, cycle 3 writes rd3.
   - src_ready_o[2]=0 in cycles 1–2.
3. x0 drop: src 1 valid with addr=0 and data=0x1234.
   - src_ready_o[1]=1 and the handshake completes.
   - No we_o pulse in the following cycles; pend_rd_o bit 0 stays 0.
4. Starvation, STARVE_LIMIT=4: sources 0 and 2 valid every cycle from cycle 0 (new addr each time).
   - Source 2 is granted no later than cycle 5.
   - Source 2 is then reloadable and its cnt restarts from 0.
5. Back-to-back throughput: source 0 valid for 8 consecutive cycles with addr 1..8.
   - src_ready_o[0] stays 1 throughout.
   - we_o=1 for cycles 1..8 with waddr_o 1..8 in order.
6. Reset mid-flight: 3 slots full, then rst_n=0 for 1 cycle.
   - During reset: src_ready_o=0.
   - After reset: we_o=0, pend_rd_o=0, and no stale write ever appears.
